regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Issue-side hazard controller for the operation-prep stage.
- Tracks which of the 32 architectural registers have a write in flight, and gates each instruction's register read (reg1, reg2) until its sources and destination are free.
- Sits between decode and operation prep. Writeback clears entries.
- Provides the stall that lets operation prep read the register file safely without forwarding.

Parameters:
- NUM_REGS, 32, number of architectural registers (address width 5).
- ZERO_REG, 31, hard-wired zero register; never marked pending.
- MAX_INFLIGHT, 4, maximum outstanding register writes.
- CNT_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clock  in  1  main clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issueValid  in  1  decode presents an instruction.
- issueReady  out  1  instruction accepted this cycle (combinational).
- issueReg1  in  5  first source register address.
- issueReg2  in  5  second source register address.
- issueUseReg2  in  1  reg2 is a real source (aluSRC = 0).
- issueWrites  in  1  instruction writes a register.
- issueDest  in  5  destination register address.
- wbValid  in  1  writeback completes this cycle (regWrite).
- wbReg  in  5  register being written back.
- flush  in  1  discard all in-flight tracking.
- pendingMask  out  32  registered pending bit per register.
- inFlight  out  CNT_W  registered count of outstanding writes.
- wbError  out  1  sticky: writeback to a non-pending register.

Behaviour:
- Reset (asynchronous): pendingMask = 0, inFlight = 0, wbError = 0. issueReady then evaluates from the cleared state.
- Hazard check uses only registered state; there is no same-cycle writeback bypass.
- hazard = pending[issueReg1] | (issueUseReg2 & pending[issueReg2]) | (issueWrites & pending[issueDest]).
- The last term is the WAW check. pending[ZERO_REG] is always 0, so ZERO_REG never creates a hazard.
- full = (inFlight == MAX_INFLIGHT).
- issueReady = ~hazard & ~(issueWrites & issueDest != ZERO_REG & full) & ~flush.
- issueReady may be high while issueValid is low.
- An issue is accepted when issueValid & issueReady.
- On an accepted issue with a real destination (issueWrites & issueDest != ZERO_REG): at the next edge pending[issueDest] <= 1 and inFlight increments.
- Issue latency: the pending bit is visible one cycle after acceptance. A back-to-back dependent instruction stalls at least until writeback.
- On writeback (wbValid):
  - If pending[wbReg] = 1: next edge pending[wbReg] <= 0 and inFlight decrements.
  - If pending[wbReg] = 0, or wbReg = ZERO_REG: no state change and wbError <= 1 (sticky until reset).
- Simultaneous issue and writeback to different registers: both take effect, and inFlight is unchanged net.
- Issue and writeback to the same register cannot both be accepted (WAW blocks the issue). If forced, set wins.
- Writeback cannot free a slot for an issue in the same cycle: full is evaluated on registered inFlight.
- On flush: next edge pendingMask = 0 and inFlight = 0. Issue is refused and any writeback that cycle is ignored (no wbError). wbError is retained.
- inFlight always equals popcount(pendingMask). It never exceeds MAX_INFLIGHT and never underflows.
- Reset mid-operation: all state clears immediately, with no waiting for the clock.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5, NUM_REGS, ZERO_REG, MAX_INFLIGHT.
  - A reg_addr_t typedef, reused by operation prep and writeback.
- One natural sub-module: regfile_hazard_check. It is purely combinational: pendingMask plus the issue fields in, hazard out. Operation prep can later reuse it for forwarding decisions.

Test Plan:
- Reset then issue reg1=1, reg2=2, issueWrites=1, issueDest=3 → issueReady=1; next cycle pendingMask=0x00000008, inFlight=1.
- With reg 3 pending, issue reg1=3 → issueReady=0. wbValid with wbReg=3 → the following cycle issueReady=1 and pendingMask=0.
- Issue dest 4,5,6,7 back-to-back → inFlight=4. A fifth issue with dest 8 stalls, while a non-writing issue (issueWrites=0, sources free) is still accepted. wbValid on reg 5 → dest-8 issue accepted the next cycle.
- Issue dest 31 (ZERO_REG) → accepted, pendingMask and inFlight unchanged. A later source read of reg 31 never stalls.
- wbValid with wbReg=9 while not pending → wbError=1 and stays 1. Assert flush with 3 pending → next cycle pendingMask=0 and inFlight=0, with wbError still 1.
- Assert reset asynchronously between clock edges with pending bits set → outputs clear before the next rising edge.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-addressing constants and types for the issue-side scoreboard,
// operation prep and writeback.
package regfile_scoreboard_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int ZERO_REG     = 31;
  localparam int MAX_INFLIGHT = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_hazard_check.sv
// Combinational RAW/WAW hazard detection against a pending-write mask.
module regfile_hazard_check
  import regfile_scoreboard_pkg::*;
(
  input  logic [NUM_REGS-1:0] pending_mask,
  input  reg_addr_t           reg1,
  input  reg_addr_t           reg2,
  input  logic                use_reg2,
  input  logic                writes,
  input  reg_addr_t           dest,
  output logic                hazard
);
  // The zero register is never marked pending, so it needs no special case here.
  assign hazard = pending_mask[reg1]
                | (use_reg2 & pending_mask[reg2])
                | (writes & pending_mask[dest]);
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard: tracks in-flight register writes and stalls issue on
// RAW/WAW hazards or when the in-flight budget is exhausted.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issueValid,
  output logic                issueReady,
  input  reg_addr_t           issueReg1,
  input  reg_addr_t           issueReg2,
  input  logic                issueUseReg2,
  input  logic                issueWrites,
  input  reg_addr_t           issueDest,
  input  logic                wbValid,
  input  reg_addr_t           wbReg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic [CNT_W-1:0]    inFlight,
  output logic                wbError
);
  logic                hazard;
  logic                full;
  logic                real_dest;
  logic                set_pend;
  logic                wb_pending;
  logic                clr_pend;
  logic                wb_bad;
  logic [NUM_REGS-1:0] mask_next;
  logic [CNT_W-1:0]    cnt_next;

  regfile_hazard_check u_hazard (
    .pending_mask (pendingMask),
    .reg1         (issueReg1),
    .reg2         (issueReg2),
    .use_reg2     (issueUseReg2),
    .writes       (issueWrites),
    .dest         (issueDest),
    .hazard       (hazard)
  );

  // Only registered state feeds issueReady; a same-cycle writeback never frees a slot.
  assign full       = (inFlight == CNT_W'(MAX_INFLIGHT));
  assign real_dest  = issueWrites & (issueDest != reg_addr_t'(ZERO_REG));
  assign issueReady = ~hazard & ~(real_dest & full) & ~flush;
  assign set_pend   = issueValid & issueReady & real_dest;

  assign wb_pending = pendingMask[wbReg] & (wbReg != reg_addr_t'(ZERO_REG));
  assign clr_pend   = wbValid & ~flush & wb_pending;
  assign wb_bad     = wbValid & ~flush & ~wb_pending;

  always_comb begin
    mask_next = pendingMask;
    cnt_next  = inFlight;
    if (flush) begin
      mask_next = '0;
      cnt_next  = '0;
    end else begin
      // Clear before set so a forced same-register collision leaves the bit set.
      if (clr_pend) mask_next[wbReg] = 1'b0;
      if (set_pend) mask_next[issueDest] = 1'b1;
      cnt_next = inFlight + CNT_W'(set_pend) - CNT_W'(clr_pend);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pendingMask <= '0;
      inFlight    <= '0;
      wbError     <= 1'b0;
    end else begin
      pendingMask <= mask_next;
      inFlight    <= cnt_next;
      if (wb_bad) wbError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a pending-set reference model.
module tb_regfile_scoreboard;
  logic        clock;
  logic        reset;
  logic        issueValid;
  logic        issueReady;
  logic [4:0]  issueReg1;
  logic [4:0]  issueReg2;
  logic        issueUseReg2;
  logic        issueWrites;
  logic [4:0]  issueDest;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic        flush;
  logic [31:0] pendingMask;
  logic [2:0]  inFlight;
  logic        wbError;

  int checks   = 0;
  int failures = 0;

  bit m_pend [32];
  bit m_err;
  bit last_ready;

  regfile_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .issueValid   (issueValid),
    .issueReady   (issueReady),
    .issueReg1    (issueReg1),
    .issueReg2    (issueReg2),
    .issueUseReg2 (issueUseReg2),
    .issueWrites  (issueWrites),
    .issueDest    (issueDest),
    .wbValid      (wbValid),
    .wbReg        (wbReg),
    .flush        (flush),
    .pendingMask  (pendingMask),
    .inFlight     (inFlight),
    .wbError      (wbError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic bit model_ready(input int r1, input int r2, input bit u2,
                                     input bit wr, input int d, input bit fl);
    bit hz;
    bit writes_real;
    hz = m_pend[r1] || (u2 && m_pend[r2]) || (wr && m_pend[d]);
    writes_real = wr && (d != 31);
    return !hz && !(writes_real && model_count() >= 4) && !fl;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
  endfunction

  task automatic idle_inputs();
    issueValid = 0; issueReg1 = 0; issueReg2 = 0; issueUseReg2 = 0;
    issueWrites = 0; issueDest = 0; wbValid = 0; wbReg = 0; flush = 0;
  endtask

  // Entered shortly after a rising edge; returns shortly after the next one.
  task automatic cycle(input bit v, input int r1, input int r2, input bit u2,
                       input bit wr, input int d, input bit wv, input int wreg,
                       input bit fl, input string tag);
    bit exp_ready;
    bit wb_ok;
    issueValid = v; issueReg1 = 5'(r1); issueReg2 = 5'(r2); issueUseReg2 = u2;
    issueWrites = wr; issueDest = 5'(d); wbValid = wv; wbReg = 5'(wreg); flush = fl;
    #1;
    exp_ready = model_ready(r1, r2, u2, wr, d, fl);
    last_ready = issueReady;
    chk({tag, ".ready"}, 32'(issueReady), 32'(exp_ready));
    if (fl) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      wb_ok = wv && (wreg != 31) && m_pend[wreg];
      if (wv && !wb_ok) m_err = 1'b1;
      if (wb_ok) m_pend[wreg] = 1'b0;
      if (v && exp_ready && wr && d != 31) m_pend[d] = 1'b1;
    end
    @(posedge clock);
    #1;
    chk({tag, ".mask"}, pendingMask, model_mask());
    chk({tag, ".inflight"}, 32'(inFlight), 32'(model_count()));
    chk({tag, ".wberr"}, 32'(wbError), 32'(m_err));
    idle_inputs();
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, ".mask"}, pendingMask, 32'h0);
    chk({tag, ".inflight"}, 32'(inFlight), 32'h0);
    chk({tag, ".wberr"}, 32'(wbError), 32'h0);
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 9) == 9) ? 31 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.mask", pendingMask, 32'h0);
    chk("reset.inflight", 32'(inFlight), 32'h0);
    chk("reset.wberr", 32'(wbError), 32'h0);
    reset = 1'b0;

    cycle(1, 1, 2, 1, 1, 3, 0, 0, 0, "t1");
    chk("t1.accept", 32'(last_ready), 32'h1);
    chk("t1.mask_const", pendingMask, 32'h0000_0008);

    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, "t2_raw");
    chk("t2.stall", 32'(last_ready), 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3, 0, "t2_wb");
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, "t2_go");
    chk("t2.go", 32'(last_ready), 32'h1);
    chk("t2.mask_const", pendingMask, 32'h0);

    for (int d = 4; d <= 7; d++) cycle(1, 0, 1, 0, 1, d, 0, 0, 0, "t3_fill");
    chk("t3.full_const", 32'(inFlight), 32'h4);
    cycle(1, 0, 1, 0, 1, 8, 0, 0, 0, "t3_full");
    chk("t3.full_stall", 32'(last_ready), 32'h0);
    cycle(1, 1, 2, 1, 0, 0, 0, 0, 0, "t3_nowrite");
    chk("t3.nowrite_ok", 32'(last_ready), 32'h1);
    cycle(0, 0, 0, 0, 0, 0, 1, 5, 0, "t3_wb5");
    cycle(1, 0, 1, 0, 1, 8, 0, 0, 0, "t3_dest8");
    chk("t3.dest8_ok", 32'(last_ready), 32'h1);
    chk("t3.mask_const", pendingMask, 32'h0000_01D0);

    cycle(1, 0, 1, 0, 1, 31, 0, 0, 0, "t4_zdest");
    chk("t4.zdest_ok", 32'(last_ready), 32'h1);
    chk("t4.mask_const", pendingMask, 32'h0000_01D0);
    cycle(1, 31, 31, 1, 0, 0, 0, 0, 0, "t4_zsrc");
    chk("t4.zsrc_ok", 32'(last_ready), 32'h1);

    cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, "t5_wb9");
    chk("t5.wberr_const", 32'(wbError), 32'h1);
    cycle(0, 0, 0, 0, 0, 0, 1, 4, 0, "t5_wb4");
    chk("t5.inflight_const", 32'(inFlight), 32'h3);
    cycle(1, 0, 1, 0, 1, 10, 1, 6, 1, "t5_flush");
    chk("t5.flush_refuse", 32'(last_ready), 32'h0);
    chk("t5.flush_mask", pendingMask, 32'h0);
    chk("t5.flush_wberr", 32'(wbError), 32'h1);

    cycle(1, 0, 1, 0, 1, 2, 0, 0, 0, "t6_set2");
    cycle(1, 0, 1, 0, 1, 3, 0, 0, 0, "t6_set3");
    async_reset("t6_async");

    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 59) async_reset("rnd_async");
      cycle(bit'($urandom_range(0, 1)), pick_reg(), pick_reg(), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), pick_reg(), ($urandom_range(0, 2) == 0),
            pick_reg(), ($urandom_range(0, 24) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
